// File: rtl/lmac_tx_arbiter.sv
// lmac_tx_arbiter: packet-granular round-robin arbiter in front of the LMAC TX FIFO write port.
// Ports: clk/reset, arb_en, req_valid/req_data/req_eop/req_ready (per requester), tx_mac_full/
// tx_mac_usedw (FIFO status), tx_mac_wr/tx_mac_data (registered write), grant_id, busy,
// err_clr/pkt_len_err (sticky over-length flag), pkt_cnt (forwarded packet count).
module lmac_tx_arbiter #(
    parameter int          NREQ         = 2,
    parameter logic [12:0] START_THRESH = 13'd6000,
    parameter logic [12:0] FULL_THRESH  = 13'd8180,
    parameter logic [15:0] MAX_WORDS    = 16'd1152
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arb_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [64*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_eop,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 tx_mac_full,
    input  logic [12:0]          tx_mac_usedw,
    output logic                 tx_mac_wr,
    output logic [63:0]          tx_mac_data,
    output logic [1:0]           grant_id,
    output logic                 busy,
    input  logic                 err_clr,
    output logic                 pkt_len_err,
    output logic [31:0]          pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        wr_q, wr_d;
    logic [63:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        g_valid;
    logic        g_eop;
    logic [63:0] g_data;
    logic        room;
    logic [1:0]  g_next;
    logic [1:0]  pick;
    logic        found;

    // Word presented by the currently granted requester.
    always_comb begin
        g_valid = 1'b0;
        g_eop   = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == 2'(i)) begin
                g_valid = req_valid[i];
                g_eop   = req_eop[i];
                g_data  = req_data[64*i +: 64];
            end
        end
    end

    // Round-robin pick: first valid at or above rr_ptr, else wrap to the lowest valid.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (2'(i) >= rr_ptr_q)) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end

    assign room   = !tx_mac_full && (tx_mac_usedw < FULL_THRESH);
    assign g_next = (grant_q == 2'(NREQ-1)) ? 2'd0 : grant_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        wcnt_d    = wcnt_q;
        wr_d      = 1'b0;
        data_d    = data_q;
        cnt_d     = cnt_q;
        // A set event later in this block overrides the clear.
        err_d     = err_clr ? 1'b0 : err_q;
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_en && found && (tx_mac_usedw < START_THRESH)) begin
                    state_d = XFER;
                    grant_d = pick;
                end
            end
            XFER: begin
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = (grant_q == 2'(i)) && room;
                end
                if (g_valid && room) begin
                    wr_d   = 1'b1;
                    data_d = g_data;
                    wcnt_d = wcnt_q + 16'd1;
                    if (g_eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = g_next;
                        cnt_d    = cnt_q + 32'd1;
                        wcnt_d   = '0;
                    end else if (wcnt_q + 16'd1 == MAX_WORDS) begin
                        state_d = DROP;
                        err_d   = 1'b1;
                    end
                end
            end
            DROP: begin
                // Tail of an over-length packet is drained and discarded.
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = (grant_q == 2'(i));
                end
                if (g_valid && g_eop) begin
                    state_d  = IDLE;
                    rr_ptr_d = g_next;
                    wcnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wcnt_q   <= '0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wcnt_q   <= wcnt_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tx_mac_wr   = wr_q;
    assign tx_mac_data = data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign pkt_len_err = err_q;
    assign pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_lmac_tx_arbiter.sv
// tb_lmac_tx_arbiter: directed and randomized bench for lmac_tx_arbiter.
// Packet sources and an output scoreboard model the packet-level behaviour.
module tb_lmac_tx_arbiter;

    localparam int NREQ = 2;
    localparam int MAXW = 1152;

    logic                clk = 1'b0;
    logic                reset;
    logic                arb_en;
    logic [NREQ-1:0]     req_valid;
    logic [64*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_eop;
    logic [NREQ-1:0]     req_ready;
    logic                tx_mac_full;
    logic [12:0]         tx_mac_usedw;
    logic                tx_mac_wr;
    logic [63:0]         tx_mac_data;
    logic [1:0]          grant_id;
    logic                busy;
    logic                err_clr;
    logic                pkt_len_err;
    logic [31:0]         pkt_cnt;

    lmac_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_eop      (req_eop),
        .req_ready    (req_ready),
        .tx_mac_full  (tx_mac_full),
        .tx_mac_usedw (tx_mac_usedw),
        .tx_mac_wr    (tx_mac_wr),
        .tx_mac_data  (tx_mac_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_clr      (err_clr),
        .pkt_len_err  (pkt_len_err),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Source model: packet lengths per requester, head packet and word index.
    int hist[NREQ][$];
    int tx_seq[NREQ];
    int widx[NREQ];
    int tot_acc[NREQ];
    // Output scoreboard.
    int out_seq[NREQ];
    bit out_active;
    int cur_src;
    int exp_w;
    int model_cnt;
    // Event logs.
    int wr_cyc[$];
    int gnt_id[$];
    int gnt_cyc[$];
    int fall_cyc[$];
    int first_rdy;
    int stall_cnt;
    bit busy_prev;
    // Stimulus knobs.
    bit gen_en;
    bit rand_env;
    bit bubble_en;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, obs, exp, cyc);
    endtask

    function automatic bit pending_any();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (tx_seq[i] < hist[i].size()) p = 1'b1;
        return p;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            hist[i].delete();
            tx_seq[i]  = 0;
            widx[i]    = 0;
            tot_acc[i] = 0;
            out_seq[i] = 0;
        end
        out_active = 1'b0;
        cur_src    = 0;
        exp_w      = 0;
        model_cnt  = 0;
        wr_cyc.delete();
        gnt_id.delete();
        gnt_cyc.delete();
        fall_cyc.delete();
        first_rdy  = -1;
        stall_cnt  = 0;
        busy_prev  = 1'b0;
    endtask

    task automatic monitor();
        logic [63:0] d;
        int s, q, w, len, lim;
        check("rdy_onehot", $onehot0(req_ready), 1);
        if (tx_mac_full || tx_mac_usedw >= 13'd8180)
            check("rdy_stall", req_ready, 0);
        if (req_ready != 0 && first_rdy < 0) first_rdy = cyc;
        if (busy && req_ready == 0) stall_cnt++;
        if (busy && !busy_prev) begin
            gnt_id.push_back(int'(grant_id));
            gnt_cyc.push_back(cyc);
        end
        if (!busy && busy_prev) fall_cyc.push_back(cyc);
        busy_prev = busy;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i] && tx_seq[i] < hist[i].size()) begin
                tot_acc[i]++;
                widx[i]++;
                if (widx[i] == hist[i][tx_seq[i]]) begin
                    widx[i] = 0;
                    tx_seq[i]++;
                end
            end
        end
        if (tx_mac_wr) begin
            wr_cyc.push_back(cyc);
            d = tx_mac_data;
            s = int'(d[63:56]);
            q = int'(d[55:32]);
            w = int'(d[31:0]);
            if (!out_active) begin
                check("wr_src_range", s < NREQ, 1);
                if (s >= NREQ) s = 0;
                cur_src    = s;
                exp_w      = 0;
                out_active = 1'b1;
            end
            check("wr_src", s, cur_src);
            check("wr_seq", q, out_seq[cur_src]);
            check("wr_idx", w, exp_w);
            exp_w++;
            len = (out_seq[cur_src] < hist[cur_src].size()) ?
                  hist[cur_src][out_seq[cur_src]] : 1;
            lim = (len > MAXW) ? MAXW : len;
            if (exp_w >= lim) begin
                out_active = 1'b0;
                out_seq[cur_src]++;
                if (len <= MAXW) model_cnt++;
            end
        end
    endtask

    task automatic drive();
        int r, len;
        if (rand_env) begin
            tx_mac_full = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)      tx_mac_usedw = 13'($urandom_range(0, 5999));
            else if (r < 8) tx_mac_usedw = 13'($urandom_range(6000, 8179));
            else            tx_mac_usedw = 13'($urandom_range(8180, 8191));
            arb_en = ($urandom_range(0, 9) != 0);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gen_en && (hist[i].size() - tx_seq[i] < 2) &&
                $urandom_range(0, 7) == 0)
                hist[i].push_back($urandom_range(1, 8));
            if (tx_seq[i] < hist[i].size()) begin
                len = hist[i][tx_seq[i]];
                req_valid[i] = (widx[i] == 0) || !bubble_en ||
                               ($urandom_range(0, 3) != 0);
                req_data[64*i +: 64] = {8'(i), 24'(tx_seq[i]), 32'(widx[i])};
                req_eop[i] = (widx[i] == len - 1);
            end else begin
                req_valid[i] = 1'b0;
                req_data[64*i +: 64] = '0;
                req_eop[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        arb_en       = 1'b1;
        tx_mac_full  = 1'b0;
        tx_mac_usedw = '0;
        err_clr      = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_eop      = '0;
        gen_en       = 1'b0;
        rand_env     = 1'b0;
        bubble_en    = 1'b0;
        clear_model();
        repeat (2) tick();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pending_any() || busy || out_active) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", n < budget, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int t, n;

        // Reset state
        do_reset();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_wr", tx_mac_wr, 0);
        check("rst_data", tx_mac_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", pkt_len_err, 0);
        check("rst_cnt", pkt_cnt, 0);

        // Single 4-word packet
        do_reset();
        hist[0].push_back(4);
        tick();
        t = cyc;
        wait_idle(50);
        repeat (2) tick();
        check("p1_first_rdy", first_rdy, t + 1);
        check("p1_nwr", wr_cyc.size(), 4);
        for (int k = 0; k < 4; k++)
            check("p1_wr_cyc", (k < wr_cyc.size()) ? wr_cyc[k] : -1, t + 2 + k);
        check("p1_busy_fall", (fall_cyc.size() > 0) ? fall_cyc[0] : -1, t + 5);
        check("p1_cnt", pkt_cnt, 1);

        // Two requesters, alternating grants
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            hist[i].push_back(3);
            hist[i].push_back(3);
        end
        tick();
        wait_idle(100);
        check("rr_ngnt", gnt_id.size(), 4);
        for (int k = 0; k < 4; k++)
            check("rr_id", (k < gnt_id.size()) ? gnt_id[k] : -1, k % 2);
        for (int k = 1; k < 4; k++)
            check("rr_gap", (k < gnt_cyc.size()) ? gnt_cyc[k] - gnt_cyc[k-1] : -1, 4);
        check("rr_cnt", pkt_cnt, 4);

        // Start threshold
        do_reset();
        tx_mac_usedw = 13'd6000;
        hist[0].push_back(2);
        tick();
        repeat (5) tick();
        check("thr_no_rdy", first_rdy, -1);
        check("thr_idle", busy, 0);
        tx_mac_usedw = 13'd5999;
        t = cyc;
        wait_idle(50);
        check("thr_first_rdy", first_rdy, t + 1);
        check("thr_cnt", pkt_cnt, 1);

        // Full pulse mid-packet
        do_reset();
        hist[0].push_back(8);
        tick();
        n = 0;
        while (wr_cyc.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        check("full_start_to", n < 50, 1);
        tx_mac_full = 1'b1;
        repeat (3) tick();
        tx_mac_full = 1'b0;
        wait_idle(50);
        check("full_stalls", stall_cnt, 3);
        check("full_nwr", wr_cyc.size(), 8);
        check("full_cnt", pkt_cnt, 1);

        // Over-length packet
        do_reset();
        hist[0].push_back(1160);
        tick();
        wait_idle(1300);
        check("long_nwr", wr_cyc.size(), MAXW);
        check("long_acc", tot_acc[0], 1160);
        check("long_err", pkt_len_err, 1);
        check("long_cnt", pkt_cnt, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("long_err_clr", pkt_len_err, 0);

        // arb_en dropped mid-packet
        do_reset();
        hist[0].push_back(5);
        hist[1].push_back(3);
        tick();
        n = 0;
        while (tot_acc[0] < 2 && n < 20) begin
            tick();
            n++;
        end
        arb_en = 1'b0;
        n = 0;
        while ((busy || out_active) && n < 50) begin
            tick();
            n++;
        end
        check("en_done_to", n < 50, 1);
        repeat (10) tick();
        check("en_nwr", wr_cyc.size(), 5);
        check("en_ngnt", gnt_id.size(), 1);
        check("en_busy", busy, 0);
        check("en_cnt", pkt_cnt, 1);
        arb_en = 1'b1;
        wait_idle(50);
        check("en_ngnt2", gnt_id.size(), 2);
        check("en_next_id", (gnt_id.size() > 1) ? gnt_id[1] : -1, 1);
        check("en_cnt2", pkt_cnt, 2);

        // Randomized traffic against the scoreboard
        do_reset();
        gen_en    = 1'b1;
        rand_env  = 1'b1;
        bubble_en = 1'b1;
        repeat (3000) tick();
        gen_en       = 1'b0;
        rand_env     = 1'b0;
        tx_mac_full  = 1'b0;
        tx_mac_usedw = '0;
        arb_en       = 1'b1;
        wait_idle(2000);
        repeat (2) tick();
        check("rnd_cnt", pkt_cnt, model_cnt);
        check("rnd_activity", model_cnt > 20, 1);
        check("rnd_busy", busy, 0);
        check("rnd_err", pkt_len_err, 0);
        for (int i = 0; i < NREQ; i++)
            check("rnd_all_out", out_seq[i], hist[i].size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
